mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_pkg.sv | 33 +++
 rtl/uart_tx_fifo.sv | 77 +++++++
 rtl/mmio_uart_tx.sv | 206 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_pkg
//  Description : Shared types and constants for the memory-mapped UART
//                transmitter. Holds the serializer state encoding, the
//                default register addresses, and the Status bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_pkg;

    // Serializer state encoding (explicit 2-bit width)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Default register addresses
    localparam logic [31:0] c_DEF_TXDATA_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] c_DEF_CTRL_ADDR   = 32'hFFFF_0004;

    // Status word bit positions: {28'b0, empty, overflow, full, busy}
    localparam int c_STAT_BUSY     = 0;
    localparam int c_STAT_FULL     = 1;
    localparam int c_STAT_OVERFLOW = 2;
    localparam int c_STAT_EMPTY    = 3;

    // Payload bits per frame (8N1)
    localparam int c_DATA_BITS = 8;

endpackage : mmio_uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO with wrap-around pointers and an occupancy count.
//                A push while full is accepted only if a pop happens in the
//                same cycle; a pop while empty is ignored.
//  Ports       : clk, reset (async, active-low)
//                push/din  - write strobe and data
//                pop/dout  - read strobe and head-of-queue data (combinational)
//                full/empty/count - occupancy flags and count 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned          c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]        c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign w_pop_ok  = pop && (r_count != '0);
    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign w_push_ok = push && ((r_count != c_FULL) || w_pop_ok);

    // Storage has no reset: stale entries are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter. Core stores to the data
//                address queue a byte; stores to the control address with
//                bit 0 set clear the sticky overflow flag. A serializer FSM
//                drains the FIFO, one frame at a time, LSB first.
//  Ports       : clk        - clock
//                reset      - asynchronous active-low reset
//                MemWrite   - core store strobe
//                DataAdr    - core store address
//                WriteData  - core store data (byte in [7:0])
//                Status     - {28'b0, empty, overflow, full, busy}
//                tx         - serial line, idle high, registered
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] TXDATA_ADDR  = c_DEF_TXDATA_ADDR,
    parameter logic [31:0] CTRL_ADDR    = c_DEF_CTRL_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] Status,
    output logic        tx
);

    localparam int unsigned c_CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] c_BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_IDX_LAST = 3'(c_DATA_BITS - 1);

    tx_state_t r_state;
    tx_state_t w_state_next;

    logic [15:0]      r_bit_cnt;
    logic [15:0]      w_cnt_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_idx_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             r_overflow;

    logic             w_sel_data;
    logic             w_ovf_clear;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_cnt_last;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [7:0]       w_fifo_dout;
    logic [c_CW-1:0]  w_count;
    logic             w_unused_wdata;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_sel_data  = MemWrite && (DataAdr == TXDATA_ADDR);
    assign w_ovf_clear = MemWrite && (DataAdr == CTRL_ADDR) && WriteData[0];
    assign w_push      = w_sel_data && (!w_fifo_full || w_pop);
    assign w_ovf_set   = w_sel_data && w_fifo_full && !w_pop;
    assign w_cnt_last  = (r_bit_cnt == c_BIT_LAST);

    // Upper store bits carry no meaning for this peripheral
    assign w_unused_wdata = ^WriteData[31:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (WriteData[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_count)
    );

    // Sticky overflow; a clear wins over a same-cycle set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_clear) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            r_bit_idx <= w_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_fifo_empty) w_state_next = ST_START;
            ST_START: if (w_cnt_last)    w_state_next = ST_DATA;
            ST_DATA:  if (w_cnt_last && (r_bit_idx == c_IDX_LAST)) w_state_next = ST_STOP;
            ST_STOP:  if (w_cnt_last)    w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Serializer FSM: datapath / output logic.
    // tx is registered, so each branch computes the level for the next
    // cycle: the bit that begins when the current period ends.
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next   = r_bit_cnt;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                w_idx_next = '0;
                w_tx_next  = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (w_cnt_last) begin
                    w_cnt_next = '0;
                    w_tx_next  = r_shift[0];
                end else begin
                    w_cnt_next = r_bit_cnt + 16'd1;
                    w_tx_next  = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == c_IDX_LAST) begin
                        w_tx_next = 1'b1;
                    end else begin
                        w_idx_next   = r_bit_idx + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                        // r_shift[1] is the bit that moves into position 0
                        w_tx_next    = r_shift[1];
                    end
                end else begin
                    w_cnt_next = r_bit_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                w_tx_next  = 1'b1;
                w_cnt_next = w_cnt_last ? 16'd0 : (r_bit_cnt + 16'd1);
            end
            default: begin
                w_cnt_next = '0;
                w_idx_next = '0;
                w_tx_next  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        Status                  = '0;
        Status[c_STAT_BUSY]     = (r_state != ST_IDLE) || (w_count != '0);
        Status[c_STAT_FULL]     = w_fifo_full;
        Status[c_STAT_OVERFLOW] = r_overflow;
        Status[c_STAT_EMPTY]    = w_fifo_empty;
    end

    assign tx = r_tx;

endmodule : mmio_uart_tx
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Directed self-checking bench for mmio_uart_tx
//                (CLKS_PER_BIT=4, FIFO_DEPTH=4). Expected bytes are queued
//                when stores are issued; a line monitor decodes each frame
//                from tx and compares against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] c_TX   = 32'hFFFF_0000;
    localparam logic [31:0] c_CTRL = 32'hFFFF_0004;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] Status;
    logic        tx;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_frames = 0;
    logic        rst_seen = 1'b0;
    logic [7:0]  sb[$];

    mmio_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4),
        .TXDATA_ADDR  (32'hFFFF_0000),
        .CTRL_ADDR    (32'hFFFF_0004)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Status    (Status),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    always @(negedge reset) rst_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One store, driven for exactly one rising edge; returns on a negedge
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((sb.size() != 0 || Status !== 32'h8) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_status", Status, 32'h8);
    endtask

    // Line monitor: samples the middle of each 4-cycle bit
    initial begin
        logic       prev;
        logic       st;
        logic       sp;
        logic [7:0] b;
        prev = 1'b1;
        b    = '0;
        forever begin
            @(negedge clk);
            if (reset && prev && !tx) begin
                rst_seen = 1'b0;
                repeat (2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                sp = tx;
                if (!rst_seen) begin
                    n_frames++;
                    chk("start_bit", st, 0);
                    chk("stop_bit", sp, 1);
                    chk("frame_queued", sb.size() > 0, 1);
                    if (sb.size() > 0) chk("frame_data", b, sb.pop_front());
                end
            end
            prev = tx;
        end
    end

    initial begin
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        reset     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_status", Status, 32'h8);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_tx", tx, 1);
        chk("post_rst_status", Status, 32'h8);

        // Single byte 0x55: latency and frame length
        sb.push_back(8'h55);
        store(c_TX, 32'h0000_0055);
        chk("lat_e1_tx", tx, 1);
        chk("lat_e1_status", Status, 32'h1);
        @(negedge clk);
        chk("lat_e2_tx", tx, 0);
        chk("lat_e2_status", Status, 32'h9);
        repeat (39) @(negedge clk);
        chk("frame_end_busy", Status, 32'h9);
        @(negedge clk);
        chk("frame_end_idle", Status, 32'h8);

        // Stores that must be ignored
        store(32'hFFFF_0008, 32'h0000_00A5);
        chk("other_addr_status", Status, 32'h8);
        store(c_CTRL, 32'h0000_00A4);
        chk("ctrl_bit0_0_status", Status, 32'h8);
        repeat (4) @(negedge clk);
        chk("ignored_tx", tx, 1);
        chk("ignored_status", Status, 32'h8);

        // Six back-to-back stores: 0x06 overflows; upper data bits ignored
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) sb.push_back(8'(i));
            store(c_TX, {24'hABCDEF, 8'(i)});
        end
        chk("full_ovf_status", Status, 32'h7);

        // Overflow clear
        store(c_CTRL, 32'h0000_0001);
        chk("ovf_clear_status", Status, 32'h3);
        wait_idle(400);

        // Push while full on the pop cycle
        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'h11 + 8'(i));
            store(c_TX, 32'h11 + 32'(i));
        end
        chk("pre_pop_full", Status, 32'h3);
        repeat (37) @(negedge clk);
        sb.push_back(8'h77);
        store(c_TX, 32'h0000_0077);
        chk("push_on_pop_status", Status, 32'h3);
        wait_idle(400);

        // Reset during bit 3 of a 0xFF frame with two bytes queued
        store(c_TX, 32'h0000_00FF);
        store(c_TX, 32'h0000_0021);
        store(c_TX, 32'h0000_0022);
        chk("pre_abort_status", Status, 32'h1);
        repeat (16) @(negedge clk);
        #1 reset = 1'b0;
        sb.delete();
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_status", Status, 32'h8);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst2_status", Status, 32'h8);
        repeat (60) @(negedge clk);
        chk("no_frame_tx", tx, 1);
        chk("no_frame_status", Status, 32'h8);
        chk("frame_count", n_frames, 12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mmio_uart_tx
`default_nettype wire
